// File: rtl/stack_engine_if.sv
// Wishbone-classic bus bundle used by the stack engine.
// The master modport is the engine (initiator) side and the slave modport
// is the memory/target side.
//   bus_cyc_o / bus_stb_o : cycle and strobe, both high for the whole access
//   bus_we_o              : 1 = write (PUSH), 0 = read (POP)
//   bus_adr_o / bus_dat_o : byte address and write data
//   bus_sel_o             : byte lanes (always all four during an access)
//   bus_dat_i             : read data returned by the target
//   bus_ack_i / bus_err_i : access completion or error termination
interface stack_engine_if #(
    parameter int WIDTH = 32
);
    logic             bus_cyc_o;
    logic             bus_stb_o;
    logic             bus_we_o;
    logic [WIDTH-1:0] bus_adr_o;
    logic [WIDTH-1:0] bus_dat_o;
    logic [3:0]       bus_sel_o;
    logic [WIDTH-1:0] bus_dat_i;
    logic             bus_ack_i;
    logic             bus_err_i;

    modport master (
        output bus_cyc_o, bus_stb_o, bus_we_o, bus_adr_o, bus_dat_o, bus_sel_o,
        input  bus_dat_i, bus_ack_i, bus_err_i
    );

    modport slave (
        input  bus_cyc_o, bus_stb_o, bus_we_o, bus_adr_o, bus_dat_o, bus_sel_o,
        output bus_dat_i, bus_ack_i, bus_err_i
    );
endinterface

// File: rtl/stack_engine.sv
// Stack engine: executes one PUSH or POP against memory over a Wishbone
// classic bus, then updates the stack pointer and/or a destination register.
// Ports:
//   clk_i, rst_i          clock, asynchronous active-low reset
//   cmd_valid_i/ready_o   command handshake: a command is taken on a rising
//                         edge where cmd_valid_i and cmd_ready_o are both 1;
//                         the fields and sp_i are sampled on that edge only
//   cmd_pop_i             1 = POP, 0 = PUSH
//   cmd_size_i            1 = byte, 2 = halfword, 3 or 0 = word
//   cmd_reg_i, cmd_data_i POP destination register, PUSH value
//   sp_i                  current stack pointer
//   sp_data_o, sp_en_o    stack pointer write port
//   write_*_o             POP destination register write port
//   done_o, fault_o       one-cycle completion / fault pulses
//   state_o               current FSM state (debug visibility)
//   bus                   Wishbone initiator (stack_engine_if.master)
module stack_engine #(
    parameter int                 WIDTH  = 32,
    parameter int                 COUNTP = 4,
    parameter logic [COUNTP-1:0]  SPREG  = COUNTP'(15)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_pop_i,
    input  logic [1:0]        cmd_size_i,
    input  logic [COUNTP-1:0] cmd_reg_i,
    input  logic [WIDTH-1:0]  cmd_data_i,
    input  logic [WIDTH-1:0]  sp_i,
    output logic [WIDTH-1:0]  sp_data_o,
    output logic [1:0]        sp_en_o,
    output logic [COUNTP-1:0] write_addr_o,
    output logic [WIDTH-1:0]  write_data_o,
    output logic [1:0]        write_en_o,
    output logic              done_o,
    output logic              fault_o,
    output logic [1:0]        state_o,
    stack_engine_if.master    bus
);

    typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, WB = 2'd2, FAULT = 2'd3} state_t;

    state_t            state;
    logic              pop_q;
    logic [1:0]        size_q;
    logic [COUNTP-1:0] reg_q;
    logic [WIDTH-1:0]  sp_q;
    logic [1:0]        size_n;

    // Size 0 behaves exactly like a word access.
    assign size_n      = (cmd_size_i == 2'd0) ? 2'd3 : cmd_size_i;
    // Gated with reset so the handshake reads 0 while reset is held.
    assign cmd_ready_o = (state == IDLE) && rst_i;
    assign state_o     = state;

    function automatic logic [WIDTH-1:0] zext(input logic [WIDTH-1:0] v,
                                              input logic [1:0]       sz);
        logic [WIDTH-1:0] mask;
        case (sz)
            2'd1:    mask = WIDTH'(8'hFF);
            2'd2:    mask = WIDTH'(16'hFFFF);
            default: mask = '1;
        endcase
        return v & mask;
    endfunction

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state         <= IDLE;
            pop_q         <= 1'b0;
            size_q        <= 2'd0;
            reg_q         <= '0;
            sp_q          <= '0;
            bus.bus_cyc_o <= 1'b0;
            bus.bus_stb_o <= 1'b0;
            bus.bus_we_o  <= 1'b0;
            bus.bus_adr_o <= '0;
            bus.bus_dat_o <= '0;
            bus.bus_sel_o <= 4'h0;
            sp_data_o     <= '0;
            sp_en_o       <= 2'd0;
            write_addr_o  <= '0;
            write_data_o  <= '0;
            write_en_o    <= 2'd0;
            done_o        <= 1'b0;
            fault_o       <= 1'b0;
        end else begin
            // Write ports and pulses are only ever live for a single cycle.
            done_o       <= 1'b0;
            fault_o      <= 1'b0;
            sp_en_o      <= 2'd0;
            sp_data_o    <= '0;
            write_en_o   <= 2'd0;
            write_addr_o <= '0;
            write_data_o <= '0;

            case (state)
                IDLE: begin
                    if (cmd_valid_i && cmd_ready_o) begin
                        pop_q  <= cmd_pop_i;
                        size_q <= size_n;
                        reg_q  <= cmd_reg_i;
                        sp_q   <= sp_i;
                        if (sp_i[1:0] != 2'b00) begin
                            // Misaligned stack pointer: never touch the bus.
                            state   <= FAULT;
                            fault_o <= 1'b1;
                        end else begin
                            state         <= BUS;
                            bus.bus_cyc_o <= 1'b1;
                            bus.bus_stb_o <= 1'b1;
                            bus.bus_we_o  <= ~cmd_pop_i;
                            bus.bus_sel_o <= 4'hF;
                            bus.bus_adr_o <= cmd_pop_i ? sp_i : sp_i - WIDTH'(4);
                            bus.bus_dat_o <= cmd_pop_i ? '0 : zext(cmd_data_i, size_n);
                        end
                    end
                end

                BUS: begin
                    // Error takes priority over a simultaneous acknowledge.
                    if (bus.bus_err_i || bus.bus_ack_i) begin
                        bus.bus_cyc_o <= 1'b0;
                        bus.bus_stb_o <= 1'b0;
                        bus.bus_we_o  <= 1'b0;
                        bus.bus_sel_o <= 4'h0;
                        bus.bus_adr_o <= '0;
                        bus.bus_dat_o <= '0;
                    end
                    if (bus.bus_err_i) begin
                        state   <= FAULT;
                        fault_o <= 1'b1;
                    end else if (bus.bus_ack_i) begin
                        state  <= WB;
                        done_o <= 1'b1;
                        if (pop_q) begin
                            write_en_o   <= size_q;
                            write_addr_o <= reg_q;
                            write_data_o <= zext(bus.bus_dat_i, size_q);
                            // Popping into SP itself: the loaded value wins,
                            // so the post-increment is suppressed.
                            if (reg_q != SPREG) begin
                                sp_en_o   <= 2'd3;
                                sp_data_o <= sp_q + WIDTH'(4);
                            end
                        end else begin
                            sp_en_o   <= 2'd3;
                            sp_data_o <= sp_q - WIDTH'(4);
                        end
                    end
                end

                WB:      state <= IDLE;
                FAULT:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stack_engine.sv
// Testbench for stack_engine: directed vectors plus randomized PUSH/POP
// traffic against a behavioural model, with a per-cycle compare process.
module tb_stack_engine;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic        cmd_pop_i;
    logic [1:0]  cmd_size_i;
    logic [3:0]  cmd_reg_i;
    logic [31:0] cmd_data_i;
    logic [31:0] sp_i;
    logic [31:0] sp_data_o;
    logic [1:0]  sp_en_o;
    logic [3:0]  write_addr_o;
    logic [31:0] write_data_o;
    logic [1:0]  write_en_o;
    logic        done_o;
    logic        fault_o;
    logic [1:0]  state_o;

    int n_checks = 0;
    int n_fail   = 0;

    // ------------------------------------------------------------ clock/reset
    always #5 clk = ~clk;

    stack_engine_if #(.WIDTH(32)) bus ();

    stack_engine #(.WIDTH(32), .COUNTP(4), .SPREG(4'd15)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_ready_o  (cmd_ready_o),
        .cmd_pop_i    (cmd_pop_i),
        .cmd_size_i   (cmd_size_i),
        .cmd_reg_i    (cmd_reg_i),
        .cmd_data_i   (cmd_data_i),
        .sp_i         (sp_i),
        .sp_data_o    (sp_data_o),
        .sp_en_o      (sp_en_o),
        .write_addr_o (write_addr_o),
        .write_data_o (write_data_o),
        .write_en_o   (write_en_o),
        .done_o       (done_o),
        .fault_o      (fault_o),
        .state_o      (state_o),
        .bus          (bus.master)
    );

    // ------------------------------------------------------------ model
    typedef struct {
        logic        misaligned;
        logic        fault;
        logic [31:0] adr;
        logic        we;
        logic [31:0] dat;
        logic [1:0]  wen;
        logic [3:0]  waddr;
        logic [31:0] wdata;
        logic [1:0]  spen;
        logic [31:0] spdata;
    } exp_t;

    typedef struct {
        int          lat;
        logic        done;
        logic        fault;
        logic        cyc_seen;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        we;
        logic [1:0]  wen;
        logic [3:0]  waddr;
        logic [31:0] wdata;
        logic [1:0]  spen;
        logic [31:0] spdata;
    } res_t;

    exp_t exp_q[$];

    function automatic exp_t model(input logic pop, input logic [1:0] size,
                                   input logic [3:0] rg, input logic [31:0] data,
                                   input logic [31:0] sp, input logic err,
                                   input logic [31:0] rdata);
        exp_t        e;
        int          sz;
        logic [31:0] mask;
        sz   = (size == 2'd0) ? 3 : int'(size);
        mask = (sz == 1) ? 32'h0000_00FF : (sz == 2) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
        e.misaligned = (sp % 4) != 0;
        e.fault      = e.misaligned || err;
        e.adr        = pop ? sp : sp - 32'd4;
        e.we         = !pop;
        e.dat        = data & mask;
        e.wen        = 2'd0;
        e.waddr      = 4'd0;
        e.wdata      = 32'd0;
        e.spen       = 2'd0;
        e.spdata     = 32'd0;
        if (!e.fault) begin
            if (pop) begin
                e.wen   = 2'(sz);
                e.waddr = rg;
                e.wdata = rdata & mask;
                if (rg != 4'd15) begin
                    e.spen   = 2'd3;
                    e.spdata = sp + 32'd4;
                end
            end else begin
                e.spen   = 2'd3;
                e.spdata = sp - 32'd4;
            end
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, expv, $time);
        end
    endtask

    // ------------------------------------------------------------ bus slave
    int          slave_waits = 0;
    logic        slave_err   = 1'b0;
    logic [31:0] slave_rdata = 32'd0;

    initial begin
        int cnt;
        cnt = 0;
        bus.bus_ack_i = 1'b0;
        bus.bus_err_i = 1'b0;
        bus.bus_dat_i = 32'd0;
        forever begin
            @(negedge clk);
            if (bus.bus_cyc_o && bus.bus_stb_o) begin
                if (cnt < slave_waits) begin
                    cnt++;
                    bus.bus_ack_i = 1'b0;
                    bus.bus_err_i = 1'b0;
                    bus.bus_dat_i = $urandom;
                end else begin
                    // With an error, sometimes also raise ack: err must win.
                    bus.bus_ack_i = slave_err ? 1'($urandom_range(0, 1)) : 1'b1;
                    bus.bus_err_i = slave_err;
                    bus.bus_dat_i = slave_rdata;
                    cnt = 0;
                end
            end else begin
                cnt = 0;
                bus.bus_ack_i = 1'b0;
                bus.bus_err_i = 1'b0;
                bus.bus_dat_i = $urandom;
            end
        end
    end

    // ------------------------------------------------------------ compare
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_i) begin
                if (bus.bus_cyc_o) begin
                    if (exp_q.size() == 0) begin
                        chk("cyc_without_cmd", 32'(bus.bus_cyc_o), 32'd0);
                    end else begin
                        e = exp_q[0];
                        chk("cyc_on_misaligned", 32'(e.misaligned), 32'd0);
                        chk("bus_stb", 32'(bus.bus_stb_o), 32'd1);
                        chk("bus_sel", 32'(bus.bus_sel_o), 32'hF);
                        chk("bus_we", 32'(bus.bus_we_o), 32'(e.we));
                        chk("bus_adr", bus.bus_adr_o, e.adr);
                        if (e.we) chk("bus_dat", bus.bus_dat_o, e.dat);
                    end
                end else begin
                    chk("stb_without_cyc", 32'(bus.bus_stb_o), 32'd0);
                end
                if (done_o || fault_o) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_completion", 32'(done_o | fault_o), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("fault_o", 32'(fault_o), 32'(e.fault));
                        chk("done_o", 32'(done_o), 32'(!e.fault));
                        chk("write_en", 32'(write_en_o), 32'(e.wen));
                        chk("sp_en", 32'(sp_en_o), 32'(e.spen));
                        if (e.wen != 0) begin
                            chk("write_addr", 32'(write_addr_o), 32'(e.waddr));
                            chk("write_data", write_data_o, e.wdata);
                        end
                        if (e.spen != 0) chk("sp_data", sp_data_o, e.spdata);
                    end
                end else begin
                    chk("idle_write_en", 32'(write_en_o), 32'd0);
                    chk("idle_sp_en", 32'(sp_en_o), 32'd0);
                end
            end
        end
    end

    // ------------------------------------------------------------ driver
    task automatic do_cmd(input logic pop, input logic [1:0] size, input logic [3:0] rg,
                          input logic [31:0] data, input logic [31:0] sp, input int waits,
                          input logic err, input logic [31:0] rdata, output res_t r);
        exp_t e;
        int   n;
        int   exp_lat;
        r = '{default: 0};
        @(negedge clk);
        slave_waits = waits;
        slave_err   = err;
        slave_rdata = rdata;
        n = 0;
        while (!cmd_ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_cmd", 32'(cmd_ready_o), 32'd1);
        e = model(pop, size, rg, data, sp, err, rdata);
        exp_q.push_back(e);
        cmd_valid_i = 1'b1;
        cmd_pop_i   = pop;
        cmd_size_i  = size;
        cmd_reg_i   = rg;
        cmd_data_i  = data;
        sp_i        = sp;
        @(posedge clk);
        @(negedge clk);
        // Inputs after the accept edge must have no effect.
        cmd_valid_i = 1'b0;
        cmd_pop_i   = 1'($urandom);
        cmd_size_i  = 2'($urandom);
        cmd_reg_i   = 4'($urandom);
        cmd_data_i  = $urandom;
        sp_i        = $urandom;
        r.lat = 1;
        while (!(done_o || fault_o) && r.lat < 100) begin
            if (bus.bus_cyc_o) begin
                r.cyc_seen = 1'b1;
                r.adr = bus.bus_adr_o;
                r.dat = bus.bus_dat_o;
                r.sel = bus.bus_sel_o;
                r.we  = bus.bus_we_o;
            end
            @(negedge clk);
            r.lat++;
        end
        chk("completion_seen", 32'(done_o | fault_o), 32'd1);
        r.done   = done_o;
        r.fault  = fault_o;
        r.wen    = write_en_o;
        r.waddr  = write_addr_o;
        r.wdata  = write_data_o;
        r.spen   = sp_en_o;
        r.spdata = sp_data_o;
        exp_lat = e.misaligned ? 1 : 2 + waits;
        chk("latency", 32'(r.lat), 32'(exp_lat));
        @(negedge clk);
        chk("pulse_one_cycle", 32'(done_o | fault_o), 32'd0);
        chk("ready_after_done", 32'(cmd_ready_o), 32'd1);
    endtask

    // ------------------------------------------------------------ stimulus
    initial begin
        res_t        r;
        logic        pop;
        logic [1:0]  size;
        logic [3:0]  rg;
        logic [31:0] sp;
        exp_t        m;

        rst_i       = 1'b0;
        cmd_valid_i = 1'b0;
        cmd_pop_i   = 1'b0;
        cmd_size_i  = 2'd0;
        cmd_reg_i   = 4'd0;
        cmd_data_i  = 32'd0;
        sp_i        = 32'd0;

        // Reset state
        #12;
        chk("rst_ready", 32'(cmd_ready_o), 32'd0);
        chk("rst_cyc", 32'(bus.bus_cyc_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_fault", 32'(fault_o), 32'd0);
        chk("rst_sp_en", 32'(sp_en_o), 32'd0);
        chk("rst_write_en", 32'(write_en_o), 32'd0);
        @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", 32'(cmd_ready_o), 32'd1);

        // Model pinned against hand-computed values
        m = model(1'b1, 2'd1, 4'd3, 32'd0, 32'h0000_0FFC, 1'b0, 32'h1234_56AB);
        chk("model_pop_byte_data", m.wdata, 32'h0000_00AB);
        chk("model_pop_byte_sp", m.spdata, 32'h0000_1000);
        m = model(1'b0, 2'd0, 4'd0, 32'hCAFE_F00D, 32'h0000_0000, 1'b0, 32'd0);
        chk("model_push_wrap_adr", m.adr, 32'hFFFF_FFFC);

        // PUSH word, two wait states
        do_cmd(1'b0, 2'd3, 4'd0, 32'hDEAD_BEEF, 32'h0000_1000, 2, 1'b0, 32'd0, r);
        chk("push_adr", r.adr, 32'h0000_0FFC);
        chk("push_dat", r.dat, 32'hDEAD_BEEF);
        chk("push_sel", 32'(r.sel), 32'hF);
        chk("push_we", 32'(r.we), 32'd1);
        chk("push_sp_en", 32'(r.spen), 32'd3);
        chk("push_sp_data", r.spdata, 32'h0000_0FFC);
        chk("push_write_en", 32'(r.wen), 32'd0);
        chk("push_done", 32'(r.done), 32'd1);

        // POP byte to r3
        do_cmd(1'b1, 2'd1, 4'd3, 32'd0, 32'h0000_0FFC, 0, 1'b0, 32'h1234_56AB, r);
        chk("pop_adr", r.adr, 32'h0000_0FFC);
        chk("pop_we", 32'(r.we), 32'd0);
        chk("pop_write_en", 32'(r.wen), 32'd1);
        chk("pop_write_addr", 32'(r.waddr), 32'd3);
        chk("pop_write_data", r.wdata, 32'h0000_00AB);
        chk("pop_sp_data", r.spdata, 32'h0000_1000);

        // PUSH halfword: zero extension on the bus
        do_cmd(1'b0, 2'd2, 4'd0, 32'hAAAA_5555, 32'h0000_2000, 1, 1'b0, 32'd0, r);
        chk("push_half_dat", r.dat, 32'h0000_5555);

        // Wraparound
        do_cmd(1'b0, 2'd3, 4'd0, 32'h1111_2222, 32'h0000_0000, 0, 1'b0, 32'd0, r);
        chk("wrap_push_adr", r.adr, 32'hFFFF_FFFC);
        do_cmd(1'b1, 2'd3, 4'd5, 32'd0, 32'hFFFF_FFFC, 1, 1'b0, 32'h0BAD_CAFE, r);
        chk("wrap_pop_sp", r.spdata, 32'h0000_0000);
        chk("wrap_pop_data", r.wdata, 32'h0BAD_CAFE);

        // Misaligned SP
        do_cmd(1'b0, 2'd3, 4'd0, 32'h1234_5678, 32'h0000_1002, 0, 1'b0, 32'd0, r);
        chk("mis_fault", 32'(r.fault), 32'd1);
        chk("mis_no_cyc", 32'(r.cyc_seen), 32'd0);
        chk("mis_write_en", 32'(r.wen), 32'd0);
        chk("mis_sp_en", 32'(r.spen), 32'd0);

        // Bus error during POP
        do_cmd(1'b1, 2'd3, 4'd2, 32'd0, 32'h0000_3000, 1, 1'b1, 32'h5A5A_5A5A, r);
        chk("err_fault", 32'(r.fault), 32'd1);
        chk("err_done", 32'(r.done), 32'd0);
        chk("err_write_en", 32'(r.wen), 32'd0);
        chk("err_sp_en", 32'(r.spen), 32'd0);

        // POP word into SP register
        do_cmd(1'b1, 2'd3, 4'd15, 32'd0, 32'h0000_0FF0, 0, 1'b0, 32'h0000_2000, r);
        chk("popsp_write_en", 32'(r.wen), 32'd3);
        chk("popsp_write_addr", 32'(r.waddr), 32'd15);
        chk("popsp_write_data", r.wdata, 32'h0000_2000);
        chk("popsp_sp_en", 32'(r.spen), 32'd0);

        // Reset in the middle of a bus cycle
        @(negedge clk);
        slave_waits = 20;
        slave_err   = 1'b0;
        exp_q.push_back(model(1'b0, 2'd3, 4'd0, 32'h7777_7777, 32'h0000_4000, 1'b0, 32'd0));
        cmd_valid_i = 1'b1;
        cmd_pop_i   = 1'b0;
        cmd_size_i  = 2'd3;
        cmd_data_i  = 32'h7777_7777;
        sp_i        = 32'h0000_4000;
        @(posedge clk);
        @(negedge clk);
        cmd_valid_i = 1'b0;
        @(negedge clk);
        chk("midbus_cyc_before", 32'(bus.bus_cyc_o), 32'd1);
        #2;
        rst_i = 1'b0;
        #1;
        chk("midbus_cyc_dropped", 32'(bus.bus_cyc_o), 32'd0);
        chk("midbus_stb_dropped", 32'(bus.bus_stb_o), 32'd0);
        chk("midbus_ready_low", 32'(cmd_ready_o), 32'd0);
        chk("midbus_write_en", 32'(write_en_o), 32'd0);
        chk("midbus_sp_en", 32'(sp_en_o), 32'd0);
        exp_q.delete();
        @(negedge clk);
        #2;
        rst_i = 1'b1;
        do_cmd(1'b0, 2'd3, 4'd0, 32'h8888_9999, 32'h0000_4000, 0, 1'b0, 32'd0, r);
        chk("after_reset_done", 32'(r.done), 32'd1);
        chk("after_reset_sp", r.spdata, 32'h0000_3FFC);

        // Randomized traffic
        for (int i = 0; i < 150; i++) begin
            pop  = 1'($urandom);
            size = 2'($urandom);
            rg   = ($urandom_range(0, 4) == 0) ? 4'd15 : 4'($urandom);
            case ($urandom_range(0, 9))
                0:       sp = 32'h0000_0000;
                1:       sp = 32'hFFFF_FFFC;
                2:       sp = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(1, 3));
                default: sp = $urandom & 32'hFFFF_FFFC;
            endcase
            do_cmd(pop, size, rg, $urandom, sp, $urandom_range(0, 3),
                   ($urandom_range(0, 7) == 0), $urandom, r);
        end

        @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/stack_engine.md
STACK_ENGINE -- requirements
Module: stack_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data, address and stack-pointer width.
REQ-002 SHALL have parameter COUNTP, default 4: register-address width.
REQ-003 SHALL have parameter SPREG, default 4'd15: stack-pointer register index.
REQ-004 SHALL have one clock; reset is asynchronous and active-low; ports clk_i and rst_i.
REQ-005 clk_i  input  1  clock; all state changes on rising edge.
REQ-006 rst_i  input  1  asynchronous active-low reset.
REQ-007 cmd_valid_i  input  1  stack command offered.
REQ-008 cmd_ready_o  output  1  engine accepts command this cycle.
REQ-009 cmd_pop_i  input  1  1=POP, 0=PUSH.
REQ-010 cmd_size_i  input  2  1=byte, 2=halfword, 3=word; 0 treated as word.
REQ-011 cmd_reg_i  input  COUNTP  POP destination register.
REQ-012 cmd_data_i  input  WIDTH  PUSH value.
REQ-013 sp_i  input  WIDTH  current stack pointer (register file SP read port).
REQ-014 sp_data_o  output  WIDTH  new stack pointer to register file.
REQ-015 sp_en_o  output  2  SP write enable (3=word write, 0=none).
REQ-016 write_addr_o  output  COUNTP; write_data_o  output  WIDTH; write_en_o  output  2: POP destination write port.
REQ-017 bus_cyc_o, bus_stb_o, bus_we_o  output  1; bus_adr_o  output  WIDTH; bus_dat_o  output  WIDTH; bus_sel_o  output  4: Wishbone-classic initiator.
REQ-018 bus_dat_i  input  WIDTH; bus_ack_i, bus_err_i  input  1.
REQ-019 done_o  output  1  one-cycle completion pulse; fault_o  output  1  one-cycle fault pulse.

Function
REQ-020 States: IDLE, BUS, WB, FAULT; cmd_ready_o SHALL be 1 only in IDLE.
REQ-021 Accept on cmd_valid_i && cmd_ready_o; command fields and sp_i captured that edge; later input changes ignored.
REQ-022 Accept with captured sp[1:0]!=0 SHALL go to FAULT without bus activity.
REQ-023 Otherwise go to BUS; PUSH address = sp-4, POP address = sp, arithmetic modulo 2^WIDTH.
REQ-024 In BUS: cyc=stb=1, sel=4'hF, we=1 for PUSH, we=0 for POP, dat_o = cmd_data zero-extended from size (byte [7:0], halfword [15:0]); all bus outputs held stable until ack or err.
REQ-025 BUS ack (err=0) SHALL go to WB, capturing bus_dat_i on POP; cyc/stb drop the cycle after ack.
REQ-026 BUS err SHALL go to FAULT; err wins if ack and err in the same cycle.
REQ-027 WB lasts exactly one cycle, asserts done_o, then IDLE.
REQ-028 WB PUSH: sp_en_o=3, sp_data_o=sp-4, write_en_o=0.
REQ-029 WB POP: write_en_o=cmd_size (0 mapped to 3), write_addr_o=cmd_reg, write_data_o=captured data zero-extended per size; sp_en_o=3, sp_data_o=sp+4.
REQ-030 WB POP with cmd_reg==SPREG: sp_en_o=0; only destination write occurs.
REQ-031 FAULT lasts one cycle, asserts fault_o, no register writes, then IDLE.
REQ-032 sp_en_o, write_en_o, done_o, fault_o SHALL be 0 outside WB/FAULT as specified.
REQ-033 Minimum latency, accept edge to done_o: bus cycle from cycle 1, ack at cycle 1 gives done_o cycle 2, cmd_ready_o cycle 3.

Reset
REQ-034 rst_i low SHALL immediately force IDLE; all outputs 0; cmd_ready_o 1 after release.
REQ-035 Reset mid-BUS SHALL drop cyc/stb asynchronously; no register write issued.

Verification
REQ-036 PUSH word 0xDEADBEEF, sp=0x1000, ack after 2 waits -> write 0xDEADBEEF at 0x0FFC, sel F; WB sp_en=3, sp_data=0x0FFC; done 1 cycle.
REQ-037 POP byte to reg 3, sp=0x0FFC, bus_dat_i=0x123456AB -> read 0x0FFC; WB write_en=1, addr 3, data 0x000000AB, sp_data=0x1000.
REQ-038 PUSH with sp=0x00000000 -> address 0xFFFFFFFC; POP with sp=0xFFFFFFFC -> new SP 0x00000000.
REQ-039 sp=0x1002 -> fault_o pulse, no cyc, no writes; bus_err_i during POP -> fault_o, write_en=sp_en=0.
REQ-040 POP word to reg 15, data 0x2000 -> write_en=3, addr 15, data 0x2000, sp_en=0.
REQ-041 rst_i low while cyc=1 -> cyc/stb 0 same cycle; next command completes normally.
